// File: rtl/mda_pkg.sv
// Shared definitions for the MDA CRTC register block: port offsets, CRTC
// register indices, mode latch bit positions and the cursor display modes.
package mda_pkg;

    localparam logic [3:0] OFF_IDX    = 4'h0;
    localparam logic [3:0] OFF_DATA   = 4'h1;
    localparam logic [3:0] OFF_MODE   = 4'h8;
    localparam logic [3:0] OFF_STATUS = 4'hA;

    localparam logic [4:0] REG_R10  = 5'd10;
    localparam logic [4:0] REG_R11  = 5'd11;
    localparam logic [4:0] REG_R12  = 5'd12;
    localparam logic [4:0] REG_R13  = 5'd13;
    localparam logic [4:0] REG_R14  = 5'd14;
    localparam logic [4:0] REG_R15  = 5'd15;
    localparam logic [4:0] REG_R16  = 5'd16;
    localparam logic [4:0] REG_R17  = 5'd17;
    localparam logic [4:0] NUM_REGS = 5'd18;

    localparam int MODE_HIRES_BIT = 0;
    localparam int MODE_VIDEN_BIT = 3;
    localparam int MODE_BLINK_BIT = 5;

    typedef enum logic [1:0] {
        CUR_STEADY     = 2'b00,
        CUR_OFF        = 2'b01,
        CUR_BLINK_FAST = 2'b10,
        CUR_BLINK_SLOW = 2'b11
    } cursor_mode_e;

    // The index and data ports are each mirrored four times in the low half.
    function automatic logic is_index_off(input logic [3:0] off);
        return (off[3] == OFF_IDX[3]) && (off[0] == OFF_IDX[0]);
    endfunction

    function automatic logic is_data_off(input logic [3:0] off);
        return (off[3] == OFF_DATA[3]) && (off[0] == OFF_DATA[0]);
    endfunction

    function automatic logic cursor_on(input cursor_mode_e mode, input logic [4:0] cnt);
        logic on;
        case (mode)
            CUR_STEADY:     on = 1'b1;
            CUR_OFF:        on = 1'b0;
            CUR_BLINK_FAST: on = cnt[3];
            CUR_BLINK_SLOW: on = cnt[4];
            default:        on = 1'b0;
        endcase
        return on;
    endfunction

endpackage

// File: rtl/mda_sync2.sv
// Multi-flop synchroniser bringing an asynchronous level into the iClk domain.
module mda_sync2 #(
    parameter int STAGES = 2
) (
    input  logic iClk,
    input  logic iRstN,
    input  logic iAsync,
    output logic oSync
);

    logic [STAGES-1:0] sync_q;

    // Shift chain; only the last stage is considered metastability-safe.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], iAsync};
        end
    end

    assign oSync = sync_q[STAGES-1];

endmodule

// File: rtl/mda_crtc_regs.sv
// MDA CPU-side I/O responder: 6845 index/data registers, mode latch, status port.
// Optional cursor blink counter is built when MDA_CURSOR_BLINK_EN is defined.
module mda_crtc_regs
    import mda_pkg::*;
#(
    parameter logic [15:0] BASE_PORT   = 16'h03B0,
    parameter logic [7:0]  MODE_RESET  = 8'h29,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        iClk,
    input  logic        iRstN,
    input  logic [15:0] iAddr,
    input  logic [7:0]  iData,
    input  logic        iWr,
    input  logic        iRd,
    output logic [7:0]  oData,
    output logic        oDataValid,
    input  logic        iHSync,
    input  logic        iVSync,
    output logic [13:0] oStartAddr,
    output logic [13:0] oCursorAddr,
    output logic [4:0]  oCursorStart,
    output logic [4:0]  oCursorEnd,
    output logic        oHiRes,
    output logic        oVideoEn,
    output logic        oBlinkEn,
    output logic        oCursorVisible
);

    logic       hit_s, wr_s, rd_s;
    logic [3:0] off_s;
    logic [7:0] rdata_s;
    logic       hs_s, vs_s;

    // Only registers with a consumer are stored; R0-R9 have no effect here.
    logic [4:0] idx_q, idx_d;
    logic [6:0] r10_q, r10_d;
    logic [4:0] r11_q, r11_d;
    logic [5:0] r12_q, r12_d;
    logic [7:0] r13_q, r13_d;
    logic [7:0] r14_q, r14_d;
    logic [7:0] r15_q, r15_d;
    logic       hires_q, hires_d;
    logic       viden_q, viden_d;
    logic       blinken_q, blinken_d;
    logic [7:0] rdata_q, rdata_d;
    logic       rvalid_q, rvalid_d;
    logic       vis_q, vis_d;
`ifdef MDA_CURSOR_BLINK_EN
    logic       vs_prev_q, vs_prev_d;
    logic [4:0] blink_q, blink_d;
`endif

    mda_sync2 #(.STAGES(SYNC_STAGES)) u_hs_sync (
        .iClk   (iClk),
        .iRstN  (iRstN),
        .iAsync (iHSync),
        .oSync  (hs_s)
    );

    mda_sync2 #(.STAGES(SYNC_STAGES)) u_vs_sync (
        .iClk   (iClk),
        .iRstN  (iRstN),
        .iAsync (iVSync),
        .oSync  (vs_s)
    );

    assign hit_s = (iAddr[15:4] == BASE_PORT[15:4]);
    assign off_s = iAddr[3:0];
    assign wr_s  = iWr & hit_s;
    // A simultaneous write wins; the read is dropped.
    assign rd_s  = iRd & ~iWr & hit_s;

    // Read data multiplexer for the addressed port.
    always_comb begin
        rdata_s = 8'hFF;
        if (is_index_off(off_s)) begin
            rdata_s = {3'b000, idx_q};
        end else if (is_data_off(off_s)) begin
            case (idx_q)
                REG_R14:          rdata_s = r14_q;
                REG_R15:          rdata_s = r15_q;
                REG_R16, REG_R17: rdata_s = 8'h00;
                default:          rdata_s = 8'h00;
            endcase
        end else if (off_s == OFF_STATUS) begin
            rdata_s = {4'hF, vs_s, 2'b00, hs_s};
        end else begin
            rdata_s = 8'hFF;
        end
    end

    // Next-state for register file, mode latch, read response and cursor.
    always_comb begin
        idx_d     = idx_q;
        r10_d     = r10_q;
        r11_d     = r11_q;
        r12_d     = r12_q;
        r13_d     = r13_q;
        r14_d     = r14_q;
        r15_d     = r15_q;
        hires_d   = hires_q;
        viden_d   = viden_q;
        blinken_d = blinken_q;

        if (wr_s) begin
            if (is_index_off(off_s)) begin
                idx_d = iData[4:0];
            end else if (is_data_off(off_s)) begin
                if (idx_q < NUM_REGS) begin
                    case (idx_q)
                        REG_R10:          r10_d = iData[6:0];
                        REG_R11:          r11_d = iData[4:0];
                        REG_R12:          r12_d = iData[5:0];
                        REG_R13:          r13_d = iData;
                        REG_R14:          r14_d = iData;
                        REG_R15:          r15_d = iData;
                        REG_R16, REG_R17: r15_d = r15_q;
                        default:          r15_d = r15_q;
                    endcase
                end else begin
                    idx_d = idx_q;
                end
            end else if (off_s == OFF_MODE) begin
                hires_d   = iData[MODE_HIRES_BIT];
                viden_d   = iData[MODE_VIDEN_BIT];
                blinken_d = iData[MODE_BLINK_BIT];
            end else begin
                idx_d = idx_q;
            end
        end else begin
            idx_d = idx_q;
        end

        rvalid_d = rd_s;
        rdata_d  = rd_s ? rdata_s : rdata_q;

`ifdef MDA_CURSOR_BLINK_EN
        vs_prev_d = vs_s;
        blink_d   = (vs_s && !vs_prev_q) ? blink_q + 5'd1 : blink_q;
        vis_d     = cursor_on(cursor_mode_e'(r10_q[6:5]), blink_q);
`else
        vis_d     = (r10_q[6:5] != CUR_OFF);
`endif
    end

    // State registers.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            idx_q     <= 5'd0;
            r10_q     <= 7'd0;
            r11_q     <= 5'd0;
            r12_q     <= 6'd0;
            r13_q     <= 8'd0;
            r14_q     <= 8'd0;
            r15_q     <= 8'd0;
            hires_q   <= MODE_RESET[MODE_HIRES_BIT];
            viden_q   <= MODE_RESET[MODE_VIDEN_BIT];
            blinken_q <= MODE_RESET[MODE_BLINK_BIT];
            rdata_q   <= 8'd0;
            rvalid_q  <= 1'b0;
            vis_q     <= 1'b1;
`ifdef MDA_CURSOR_BLINK_EN
            vs_prev_q <= 1'b0;
            blink_q   <= 5'd0;
`endif
        end else begin
            idx_q     <= idx_d;
            r10_q     <= r10_d;
            r11_q     <= r11_d;
            r12_q     <= r12_d;
            r13_q     <= r13_d;
            r14_q     <= r14_d;
            r15_q     <= r15_d;
            hires_q   <= hires_d;
            viden_q   <= viden_d;
            blinken_q <= blinken_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            vis_q     <= vis_d;
`ifdef MDA_CURSOR_BLINK_EN
            vs_prev_q <= vs_prev_d;
            blink_q   <= blink_d;
`endif
        end
    end

    assign oData          = rdata_q;
    assign oDataValid     = rvalid_q;
    assign oStartAddr     = {r12_q, r13_q};
    assign oCursorAddr    = {r14_q[5:0], r15_q};
    assign oCursorStart   = r10_q[4:0];
    assign oCursorEnd     = r11_q;
    assign oHiRes         = hires_q;
    assign oVideoEn       = viden_q;
    assign oBlinkEn       = blinken_q;
    assign oCursorVisible = vis_q;

endmodule

// File: tb/tb_mda_crtc_regs.sv
// Self-checking bench for mda_crtc_regs: directed vector table, hand sequences
// for sync/blink/reset corners, and randomized I/O against a port-level model.
module tb_mda_crtc_regs;

    localparam int SS = 2;

    logic        iClk, iRstN;
    logic [15:0] iAddr;
    logic [7:0]  iData;
    logic        iWr, iRd;
    logic [7:0]  oData;
    logic        oDataValid;
    logic        iHSync, iVSync;
    logic [13:0] oStartAddr, oCursorAddr;
    logic [4:0]  oCursorStart, oCursorEnd;
    logic        oHiRes, oVideoEn, oBlinkEn, oCursorVisible;

    mda_crtc_regs #(.BASE_PORT(16'h03B0), .MODE_RESET(8'h29), .SYNC_STAGES(SS)) dut (
        .iClk(iClk), .iRstN(iRstN), .iAddr(iAddr), .iData(iData), .iWr(iWr), .iRd(iRd),
        .oData(oData), .oDataValid(oDataValid), .iHSync(iHSync), .iVSync(iVSync),
        .oStartAddr(oStartAddr), .oCursorAddr(oCursorAddr), .oCursorStart(oCursorStart),
        .oCursorEnd(oCursorEnd), .oHiRes(oHiRes), .oVideoEn(oVideoEn), .oBlinkEn(oBlinkEn),
        .oCursorVisible(oCursorVisible)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int checks = 0;
    int errors = 0;

    // Reference model: the programmer-visible state of the adapter.
    logic [7:0] m_reg [0:17];
    logic [4:0] m_idx;
    logic [7:0] m_mode;
    logic [4:0] m_cnt;
    logic       m_hs, m_vs;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [15:0] addr;
        logic [7:0]  data;
        logic        exp_v;
        logic [7:0]  exp_q;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 18; i++) m_reg[i] = 8'h00;
        m_idx  = 5'd0;
        m_mode = 8'h29;
        m_cnt  = 5'd0;
    endtask

    function automatic logic m_hit(input logic [15:0] a);
        return a[15:4] == 12'h03B;
    endfunction

    task automatic model_write(input logic [15:0] a, input logic [7:0] d);
        int off;
        off = int'(a[3:0]);
        if (m_hit(a)) begin
            if (off < 8 && off % 2 == 0) m_idx = d[4:0];
            else if (off < 8) begin
                if (m_idx < 5'd16) m_reg[m_idx] = d;
            end
            else if (off == 8) m_mode = d;
        end
    endtask

    function automatic logic [7:0] model_read(input logic [15:0] a);
        int off;
        off = int'(a[3:0]);
        if (off < 8 && off % 2 == 0) return {3'b000, m_idx};
        if (off < 8) return (m_idx == 5'd14 || m_idx == 5'd15) ? m_reg[m_idx] : 8'h00;
        if (off == 10) return {4'hF, m_vs, 2'b00, m_hs};
        return 8'hFF;
    endfunction

    function automatic logic model_vis();
        logic [1:0] cm;
        cm = m_reg[10][6:5];
`ifdef MDA_CURSOR_BLINK_EN
        if (cm == 2'b00) return 1'b1;
        if (cm == 2'b01) return 1'b0;
        if (cm == 2'b10) return m_cnt[3];
        return m_cnt[4];
`else
        return cm != 2'b01;
`endif
    endfunction

    task automatic chk_outputs(input string tag);
        chk({tag, ".start"},  32'(oStartAddr),   32'({m_reg[12][5:0], m_reg[13]}));
        chk({tag, ".cursor"}, 32'(oCursorAddr),  32'({m_reg[14][5:0], m_reg[15]}));
        chk({tag, ".cstart"}, 32'(oCursorStart), 32'(m_reg[10][4:0]));
        chk({tag, ".cend"},   32'(oCursorEnd),   32'(m_reg[11][4:0]));
        chk({tag, ".mode"},   32'({oHiRes, oVideoEn, oBlinkEn}),
            32'({m_mode[0], m_mode[3], m_mode[5]}));
        chk({tag, ".vis"},    32'(oCursorVisible), 32'(model_vis()));
    endtask

    // One bus cycle from a negedge; returns response and valid one cycle later.
    task automatic do_op(input logic wr, input logic rd, input logic [15:0] a, input logic [7:0] d,
                         output logic v, output logic [7:0] q, output logic v2);
        iAddr = a; iData = d; iWr = wr; iRd = rd;
        @(negedge iClk);
        iWr = 1'b0; iRd = 1'b0;
        v = oDataValid; q = oData;
        @(negedge iClk);
        v2 = oDataValid;
    endtask

    task automatic add(input logic wr, input logic rd, input logic [15:0] a, input logic [7:0] d,
                       input logic ev, input logic [7:0] eq);
        vec_t t;
        t.wr = wr; t.rd = rd; t.addr = a; t.data = d; t.exp_v = ev; t.exp_q = eq;
        vecs.push_back(t);
    endtask

    task automatic set_syncs(input logic hs, input logic vs);
        @(negedge iClk);
        #3;
        if (vs && !m_vs) m_cnt = m_cnt + 5'd1;
        iHSync = hs; iVSync = vs; m_hs = hs; m_vs = vs;
        repeat (SS + 3) @(negedge iClk);
    endtask

    task automatic read_chk(input string nm, input logic [15:0] a);
        logic v, v2;
        logic [7:0] q;
        do_op(1'b0, 1'b1, a, 8'h00, v, q, v2);
        chk({nm, ".valid"}, 32'(v), 32'd1);
        chk({nm, ".data"}, 32'(q), 32'(model_read(a)));
        chk({nm, ".drop"}, 32'(v2), 32'd0);
    endtask

    task automatic write_op(input logic [15:0] a, input logic [7:0] d);
        logic v, v2;
        logic [7:0] q;
        do_op(1'b1, 1'b0, a, d, v, q, v2);
        model_write(a, d);
    endtask

    initial begin
        logic v, v2;
        logic [7:0] q;
        logic [7:0] e0, e1, e2;

        iRstN = 1'b0; iAddr = 16'h0; iData = 8'h0; iWr = 1'b0; iRd = 1'b0;
        iHSync = 1'b0; iVSync = 1'b0; m_hs = 1'b0; m_vs = 1'b0;
        model_reset();

        add(0, 1, 16'h03BA, 8'h00, 1, 8'hF0);
        add(1, 0, 16'h03B4, 8'h0E, 0, 8'h00);
        add(1, 0, 16'h03B5, 8'h07, 0, 8'h00);
        add(1, 0, 16'h03B4, 8'h0F, 0, 8'h00);
        add(1, 0, 16'h03B5, 8'hD0, 0, 8'h00);
        add(0, 1, 16'h03B5, 8'h00, 1, 8'hD0);
        add(0, 1, 16'h03B4, 8'h00, 1, 8'h0F);
        add(1, 0, 16'h03B4, 8'h0E, 0, 8'h00);
        add(0, 1, 16'h03B5, 8'h00, 1, 8'h07);
        add(0, 1, 16'h03B1, 8'h00, 1, 8'h07);
        add(1, 0, 16'h03B4, 8'h0C, 0, 8'h00);
        add(1, 0, 16'h03B5, 8'h12, 0, 8'h00);
        add(0, 1, 16'h03B7, 8'h00, 1, 8'h00);
        add(1, 0, 16'h03B2, 8'h14, 0, 8'h00);
        add(1, 0, 16'h03B5, 8'h55, 0, 8'h00);
        add(0, 1, 16'h03B5, 8'h00, 1, 8'h00);
        add(0, 1, 16'h03B6, 8'h00, 1, 8'h14);
        add(1, 0, 16'h03B4, 8'h10, 0, 8'h00);
        add(1, 0, 16'h03B5, 8'hAA, 0, 8'h00);
        add(0, 1, 16'h03B5, 8'h00, 1, 8'h00);
        add(0, 1, 16'h03B8, 8'h00, 1, 8'hFF);
        add(0, 1, 16'h03BF, 8'h00, 1, 8'hFF);
        add(0, 1, 16'h03C5, 8'h00, 0, 8'h00);
        add(0, 1, 16'h03A0, 8'h00, 0, 8'h00);
        add(1, 0, 16'h03B4, 8'h0A, 0, 8'h00);
        add(1, 0, 16'h03B5, 8'h0B, 0, 8'h00);
        add(1, 0, 16'h03B4, 8'h0B, 0, 8'h00);
        add(1, 0, 16'h03B5, 8'h0C, 0, 8'h00);
        add(1, 1, 16'h03B4, 8'h0E, 0, 8'h00);
        add(0, 1, 16'h03B5, 8'h00, 1, 8'h07);
        add(1, 0, 16'h03BA, 8'h00, 0, 8'h00);
        add(0, 1, 16'h03BA, 8'h00, 1, 8'hF0);
        add(1, 0, 16'h13B4, 8'h03, 0, 8'h00);
        add(0, 1, 16'h03B4, 8'h00, 1, 8'h0E);

        repeat (3) @(negedge iClk);
        chk("rst.data",   32'(oData), 32'h00);
        chk("rst.valid",  32'(oDataValid), 32'd0);
        chk("rst.start",  32'(oStartAddr), 32'h0000);
        chk("rst.cursor", 32'(oCursorAddr), 32'h0000);
        chk("rst.mode",   32'({oHiRes, oVideoEn, oBlinkEn}), 32'b111);
        chk("rst.vis",    32'(oCursorVisible), 32'd1);
        iRstN = 1'b1;
        @(negedge iClk);

        foreach (vecs[i]) begin
            do_op(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data, v, q, v2);
            if (vecs[i].wr) model_write(vecs[i].addr, vecs[i].data);
            chk($sformatf("vec%0d.valid", i), 32'(v), 32'(vecs[i].exp_v));
            if (vecs[i].exp_v) chk($sformatf("vec%0d.data", i), 32'(q), 32'(vecs[i].exp_q));
            chk($sformatf("vec%0d.drop", i), 32'(v2), 32'd0);
        end
        chk("tbl.cursor", 32'(oCursorAddr), 32'h07D0);
        chk("tbl.start",  32'(oStartAddr), 32'h1200);
        chk("tbl.cstart", 32'(oCursorStart), 32'h0B);
        chk("tbl.cend",   32'(oCursorEnd), 32'h0C);
        chk("tbl.mode",   32'({oHiRes, oVideoEn, oBlinkEn}), 32'b111);

        write_op(16'h03B8, 8'h08);
        chk("mode08", 32'({oHiRes, oVideoEn, oBlinkEn}), 32'b010);
        write_op(16'h03B8, 8'h21);
        chk("mode21", 32'({oHiRes, oVideoEn, oBlinkEn}), 32'b101);

        // Back-to-back reads on consecutive cycles.
        e0 = model_read(16'h03B4); e1 = model_read(16'h03B5); e2 = model_read(16'h03BA);
        iAddr = 16'h03B4; iRd = 1'b1;
        @(negedge iClk); chk("b2b0.v", 32'(oDataValid), 32'd1); chk("b2b0.d", 32'(oData), 32'(e0));
        iAddr = 16'h03B5;
        @(negedge iClk); chk("b2b1.v", 32'(oDataValid), 32'd1); chk("b2b1.d", 32'(oData), 32'(e1));
        iAddr = 16'h03BA;
        @(negedge iClk); chk("b2b2.v", 32'(oDataValid), 32'd1); chk("b2b2.d", 32'(oData), 32'(e2));
        iRd = 1'b0;
        @(negedge iClk); chk("b2b.end", 32'(oDataValid), 32'd0);

        set_syncs(1'b1, 1'b0); read_chk("st.hs", 16'h03BA);
        chk("st.F1", 32'(model_read(16'h03BA)), 32'hF1);
        set_syncs(1'b1, 1'b1); read_chk("st.both", 16'h03BA);
        set_syncs(1'b0, 1'b1); read_chk("st.vs", 16'h03BA);
        set_syncs(1'b0, 1'b0); read_chk("st.none", 16'h03BA);

        // Cursor blink: 16 VSync pulses in fast mode, then off, then slow mode.
        write_op(16'h03B4, 8'h0A);
        write_op(16'h03B5, 8'h40);
        for (int p = 0; p < 16; p++) begin
            set_syncs(1'b0, 1'b1);
            set_syncs(1'b0, 1'b0);
            chk($sformatf("blink10.%0d", p), 32'(oCursorVisible), 32'(model_vis()));
        end
        write_op(16'h03B5, 8'h20);
        for (int p = 0; p < 3; p++) begin
            set_syncs(1'b0, 1'b1);
            set_syncs(1'b0, 1'b0);
            chk($sformatf("blink01.%0d", p), 32'(oCursorVisible), 32'd0);
        end
        write_op(16'h03B5, 8'h60);
        for (int p = 0; p < 12; p++) begin
            set_syncs(1'b0, 1'b1);
            set_syncs(1'b0, 1'b0);
            chk($sformatf("blink11.%0d", p), 32'(oCursorVisible), 32'(model_vis()));
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [15:0] a;
            logic [7:0]  d;
            int r, k;
            if (n % 40 == 39) set_syncs(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            r = $urandom_range(0, 99);
            a = (r < 8) ? (16'h03C0 | 16'($urandom_range(0, 15))) : (16'h03B0 | 16'($urandom_range(0, 15)));
            d = 8'($urandom);
            if (a[0] == 1'b0 && a[3] == 1'b0 && $urandom_range(0, 3) != 0) d[4:0] = 5'($urandom_range(10, 17));
            k = $urandom_range(0, 99);
            if (k < 45) begin
                do_op(1'b1, 1'b0, a, d, v, q, v2);
                model_write(a, d);
                chk("rnd.wr.valid", 32'(v), 32'd0);
            end else if (k < 90) begin
                e0 = model_read(a);
                do_op(1'b0, 1'b1, a, d, v, q, v2);
                chk("rnd.rd.valid", 32'(v), 32'(m_hit(a)));
                if (m_hit(a)) chk("rnd.rd.data", 32'(q), 32'(e0));
            end else begin
                do_op(1'b1, 1'b1, a, d, v, q, v2);
                model_write(a, d);
                chk("rnd.both.valid", 32'(v), 32'd0);
            end
            chk("rnd.drop", 32'(v2), 32'd0);
            chk_outputs("rnd");
        end

        // Reset asserted while a read is in flight.
        set_syncs(1'b0, 1'b0);
        iAddr = 16'h03BA; iRd = 1'b1;
        #2 iRstN = 1'b0;
        @(posedge iClk); #1;
        chk("rstrd.valid0", 32'(oDataValid), 32'd0);
        @(negedge iClk);
        iRd = 1'b0;
        chk("rstrd.valid1", 32'(oDataValid), 32'd0);
        chk("rstrd.data", 32'(oData), 32'h00);
        #2 iRstN = 1'b1;
        model_reset();
        @(negedge iClk);
        chk("rstrd.valid2", 32'(oDataValid), 32'd0);
        chk_outputs("rstrd");
        read_chk("rstrd.status", 16'h03BA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
